// File: rtl/pipelined_quality_sorter_if.sv
// Event bus of the quality sorter: candidate inputs, threshold, ranked winners and overflow status.
interface pipelined_quality_sorter_if #(
  parameter int unsigned N_INPUTS  = 8,
  parameter int unsigned N_OUTPUTS = 3,
  parameter int unsigned QUAL_W    = 4,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned IDX_W     = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
);
  logic                  in_strobe;
  logic [N_INPUTS-1:0]   in_valid;
  logic [QUAL_W-1:0]     in_quality [N_INPUTS];
  logic [DATA_W-1:0]     in_data    [N_INPUTS];
  logic [QUAL_W-1:0]     min_quality;
  logic                  overflow_clear;

  logic                  out_strobe;
  logic [N_OUTPUTS-1:0]  out_valid;
  logic [QUAL_W-1:0]     out_quality [N_OUTPUTS];
  logic [DATA_W-1:0]     out_data    [N_OUTPUTS];
  logic [IDX_W-1:0]      out_index   [N_OUTPUTS];
  logic                  out_overflow;
  logic [15:0]           overflow_count;

  modport master (
    output in_strobe, in_valid, in_quality, in_data, min_quality, overflow_clear,
    input  out_strobe, out_valid, out_quality, out_data, out_index, out_overflow, overflow_count
  );

  modport slave (
    input  in_strobe, in_valid, in_quality, in_data, min_quality, overflow_clear,
    output out_strobe, out_valid, out_quality, out_data, out_index, out_overflow, overflow_count
  );
endinterface

// File: rtl/pipelined_quality_sorter.sv
// Fully pipelined top-N selector: one argmax stage per output slot, winners in descending quality,
// lowest channel index breaks ties; flags and counts events with more than N_OUTPUTS candidates.
module pipelined_quality_sorter #(
  parameter int unsigned N_INPUTS  = 8,
  parameter int unsigned N_OUTPUTS = 3,
  parameter int unsigned QUAL_W    = 4,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned IDX_W     = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
  input logic                       clk,
  input logic                       reset,
  pipelined_quality_sorter_if.slave bus
);
  localparam int unsigned LATENCY  = N_OUTPUTS + 1;
  localparam int unsigned N_STAGES = LATENCY - 1;
  localparam int unsigned CNT_W    = $clog2(N_INPUTS + 1);
  localparam int unsigned OVF_W    = 16;

  // Candidate set seen by sort stages; index s feeds stage s+1.
  logic [N_INPUTS-1:0]  st_mask [N_STAGES];
  logic [QUAL_W-1:0]    st_qual [N_STAGES][N_INPUTS];
  logic [DATA_W-1:0]    st_data [N_STAGES][N_INPUTS];

  // Result slots per stage; stage 0 holds an empty result.
  logic [N_STAGES:0]    st_strobe;
  logic [N_STAGES:0]    st_ovf;
  logic [N_OUTPUTS-1:0] st_valid [N_STAGES+1];
  logic [QUAL_W-1:0]    st_sq    [N_STAGES+1][N_OUTPUTS];
  logic [DATA_W-1:0]    st_sd    [N_STAGES+1][N_OUTPUTS];
  logic [IDX_W-1:0]     st_si    [N_STAGES+1][N_OUTPUTS];

  logic [OVF_W-1:0]     ovf_count;

  logic [N_INPUTS-1:0]  qual_mask_c;
  logic [CNT_W-1:0]     qual_cnt_c;
  logic [N_STAGES-1:0]  sel_found_c;
  logic [IDX_W-1:0]     sel_idx_c  [N_STAGES];
  logic [QUAL_W-1:0]    sel_qual_c [N_STAGES];
  logic [DATA_W-1:0]    sel_data_c [N_STAGES];
  logic [N_INPUTS-1:0]  sel_rest_c [N_STAGES];

  // Qualification and candidate popcount for the incoming event.
  always_comb begin
    qual_mask_c = '0;
    qual_cnt_c  = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      qual_mask_c[i] = bus.in_strobe && bus.in_valid[i] && (bus.in_quality[i] >= bus.min_quality);
      qual_cnt_c     = qual_cnt_c + CNT_W'(qual_mask_c[i]);
    end
  end

  // Per-stage argmax; strict compare keeps the lowest index on ties.
  always_comb begin : argmax
    logic              found;
    logic [IDX_W-1:0]  best_idx;
    logic [QUAL_W-1:0] best_qual;
    logic [DATA_W-1:0] best_data;
    found       = 1'b0;
    best_idx    = '0;
    best_qual   = '0;
    best_data   = '0;
    sel_found_c = '0;
    for (int s = 0; s < N_STAGES; s++) begin
      found     = 1'b0;
      best_idx  = '0;
      best_qual = '0;
      best_data = '0;
      for (int i = 0; i < N_INPUTS; i++) begin
        if (st_mask[s][i] && (!found || (st_qual[s][i] > best_qual))) begin
          found     = 1'b1;
          best_idx  = IDX_W'(i);
          best_qual = st_qual[s][i];
          best_data = st_data[s][i];
        end
      end
      sel_found_c[s] = found;
      sel_idx_c[s]   = best_idx;
      sel_qual_c[s]  = best_qual;
      sel_data_c[s]  = best_data;
      sel_rest_c[s]  = st_mask[s] & ~(N_INPUTS'(found) << best_idx);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_strobe <= '0;
      st_ovf    <= '0;
      for (int s = 0; s < N_STAGES; s++) begin
        st_mask[s] <= '0;
        for (int i = 0; i < N_INPUTS; i++) begin
          st_qual[s][i] <= '0;
          st_data[s][i] <= '0;
        end
      end
      for (int s = 0; s <= N_STAGES; s++) begin
        st_valid[s] <= '0;
        for (int j = 0; j < N_OUTPUTS; j++) begin
          st_sq[s][j] <= '0;
          st_sd[s][j] <= '0;
          st_si[s][j] <= '0;
        end
      end
    end else begin
      st_strobe[0] <= bus.in_strobe;
      st_ovf[0]    <= (qual_cnt_c > CNT_W'(N_OUTPUTS));
      st_mask[0]   <= qual_mask_c;
      for (int i = 0; i < N_INPUTS; i++) begin
        st_qual[0][i] <= bus.in_quality[i];
        st_data[0][i] <= bus.in_data[i];
      end
      st_valid[0] <= '0;
      for (int j = 0; j < N_OUTPUTS; j++) begin
        st_sq[0][j] <= '0;
        st_sd[0][j] <= '0;
        st_si[0][j] <= '0;
      end
      for (int s = 1; s <= N_STAGES; s++) begin
        st_strobe[s] <= st_strobe[s-1];
        st_ovf[s]    <= st_ovf[s-1];
        if (s < N_STAGES) begin
          st_mask[s] <= sel_rest_c[s-1];
          st_qual[s] <= st_qual[s-1];
          st_data[s] <= st_data[s-1];
        end
        for (int j = 0; j < N_OUTPUTS; j++) begin
          if (j == s - 1) begin
            st_valid[s][j] <= sel_found_c[s-1];
            st_sq[s][j]    <= sel_qual_c[s-1];
            st_sd[s][j]    <= sel_data_c[s-1];
            st_si[s][j]    <= sel_idx_c[s-1];
          end else begin
            st_valid[s][j] <= st_valid[s-1][j];
            st_sq[s][j]    <= st_sq[s-1][j];
            st_sd[s][j]    <= st_sd[s-1][j];
            st_si[s][j]    <= st_si[s-1][j];
          end
        end
      end
    end
  end

  // Counts on the same edge the overflowed result is registered, so both are visible together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_count <= '0;
    end else if (bus.overflow_clear) begin
      ovf_count <= '0;
    end else if (st_ovf[N_STAGES-1] && (ovf_count != {OVF_W{1'b1}})) begin
      ovf_count <= ovf_count + OVF_W'(1);
    end
  end

  assign bus.out_strobe     = st_strobe[N_STAGES];
  assign bus.out_overflow   = st_ovf[N_STAGES];
  assign bus.out_valid      = st_valid[N_STAGES];
  assign bus.out_quality    = st_sq[N_STAGES];
  assign bus.out_data       = st_sd[N_STAGES];
  assign bus.out_index      = st_si[N_STAGES];
  assign bus.overflow_count = ovf_count;
endmodule

// File: tb/tb_pipelined_quality_sorter.sv
// Directed, table-driven bench for pipelined_quality_sorter at default parameters.
module tb_pipelined_quality_sorter;
  localparam int unsigned NI = 8;
  localparam int unsigned NO = 3;
  localparam int unsigned QW = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned IW = 3;

  logic clk;
  logic reset;

  pipelined_quality_sorter_if #(.N_INPUTS(NI), .N_OUTPUTS(NO), .QUAL_W(QW), .DATA_W(DW), .IDX_W(IW)) bus ();

  pipelined_quality_sorter #(.N_INPUTS(NI), .N_OUTPUTS(NO), .QUAL_W(QW), .DATA_W(DW), .IDX_W(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]        valid;
    logic [0:7][3:0]   qual;
    logic [3:0]        minq;
    logic [2:0]        ev;
    logic [0:2][3:0]   eq;
    logic [0:2][2:0]   ei;
    logic              eovf;
  } vec_t;

  vec_t vecs [8];
  int   errors;
  int   checks;
  int   exp_cnt;

  function automatic logic [15:0] pay(input int ch, input logic [7:0] tag);
    return {4'hA, 4'(ch), tag};
  endfunction

  function automatic vec_t mk(input logic [7:0] valid, input logic [0:7][3:0] qual, input logic [3:0] minq,
                              input logic [2:0] ev, input logic [0:2][3:0] eq, input logic [0:2][2:0] ei,
                              input logic eovf);
    vec_t v;
    v.valid = valid; v.qual = qual; v.minq = minq;
    v.ev = ev; v.eq = eq; v.ei = ei; v.eovf = eovf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_event(input logic [7:0] valid, input logic [0:7][3:0] qual, input logic [3:0] minq,
                             input logic [7:0] tag);
    bus.in_strobe   = 1'b1;
    bus.in_valid    = valid;
    bus.min_quality = minq;
    for (int i = 0; i < 8; i++) begin
      bus.in_quality[i] = qual[i];
      bus.in_data[i]    = pay(i, tag);
    end
  endtask

  // Valid lines are left high while idle: they must be ignored without a strobe.
  task automatic idle_inputs();
    bus.in_strobe   = 1'b0;
    bus.in_valid    = 8'hFF;
    bus.min_quality = 4'd0;
    for (int i = 0; i < 8; i++) begin
      bus.in_quality[i] = 4'(i + 3);
      bus.in_data[i]    = 16'hFFFF;
    end
  endtask

  task automatic check_slots(input string tag, input vec_t v, input logic [7:0] dtag);
    if (v.eovf && exp_cnt != 16'hFFFF) exp_cnt++;
    chk({tag, ".strobe"}, 32'(bus.out_strobe), 32'd1);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'(v.ev));
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s.q%0d", tag, k), 32'(bus.out_quality[k]), 32'(v.eq[k]));
      chk($sformatf("%s.i%0d", tag, k), 32'(bus.out_index[k]), 32'(v.ei[k]));
      chk($sformatf("%s.d%0d", tag, k), 32'(bus.out_data[k]),
          v.ev[k] ? 32'(pay(int'(v.ei[k]), dtag)) : 32'd0);
    end
    chk({tag, ".ovf"}, 32'(bus.out_overflow), 32'(v.eovf));
    chk({tag, ".cnt"}, 32'(bus.overflow_count), 32'(exp_cnt));
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, ".strobe"}, 32'(bus.out_strobe), 32'd0);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".ovf"}, 32'(bus.out_overflow), 32'd0);
    chk({tag, ".q0"}, 32'(bus.out_quality[0]), 32'd0);
    chk({tag, ".d0"}, 32'(bus.out_data[0]), 32'd0);
  endtask

  initial begin
    logic [0:7][3:0] qall;
    errors  = 0;
    checks  = 0;
    exp_cnt = 0;

    vecs[0] = mk(8'hFF, {4'd3,4'd9,4'd1,4'd9,4'd7,4'd0,4'd2,4'd5}, 4'd0,
                 3'b111, {4'd9,4'd9,4'd7}, {3'd1,3'd3,3'd4}, 1'b1);
    vecs[1] = mk(8'hFF, {4'd3,4'd9,4'd1,4'd9,4'd7,4'd0,4'd2,4'd5}, 4'd8,
                 3'b011, {4'd9,4'd9,4'd0}, {3'd1,3'd3,3'd0}, 1'b0);
    vecs[2] = mk(8'b0100_0100, {4'd15,4'd15,4'd5,4'd15,4'd15,4'd15,4'd5,4'd15}, 4'd0,
                 3'b011, {4'd5,4'd5,4'd0}, {3'd2,3'd6,3'd0}, 1'b0);
    vecs[3] = mk(8'hFF, {8{4'd0}}, 4'd0,
                 3'b111, {4'd0,4'd0,4'd0}, {3'd0,3'd1,3'd2}, 1'b1);
    vecs[4] = mk(8'h00, {8{4'd12}}, 4'd0,
                 3'b000, {4'd0,4'd0,4'd0}, {3'd0,3'd0,3'd0}, 1'b0);
    vecs[5] = mk(8'b1000_0011, {4'd2,4'd15,4'd9,4'd9,4'd9,4'd9,4'd9,4'd15}, 4'd0,
                 3'b111, {4'd15,4'd15,4'd2}, {3'd1,3'd7,3'd0}, 1'b0);
    vecs[6] = mk(8'b1001_0011, {4'd2,4'd15,4'd9,4'd9,4'd9,4'd9,4'd9,4'd15}, 4'd0,
                 3'b111, {4'd15,4'd15,4'd9}, {3'd1,3'd7,3'd4}, 1'b1);
    vecs[7] = mk(8'b1001_0011, {4'd2,4'd15,4'd9,4'd9,4'd9,4'd9,4'd9,4'd15}, 4'd15,
                 3'b011, {4'd15,4'd15,4'd0}, {3'd1,3'd7,3'd0}, 1'b0);

    // Power-on reset
    reset = 1'b1;
    bus.overflow_clear = 1'b0;
    idle_inputs();
    step();
    step();
    check_quiet("por");
    chk("por.cnt", 32'(bus.overflow_count), 32'd0);
    #3 reset = 1'b0;

    // Table of isolated events, each checked at latency 4 and one cycle after.
    for (int v = 0; v < 8; v++) begin
      drive_event(vecs[v].valid, vecs[v].qual, vecs[v].minq, 8'(v));
      step();
      idle_inputs();
      step();
      step();
      step();
      check_slots($sformatf("vec%0d", v), vecs[v], 8'(v));
      step();
      check_quiet($sformatf("vec%0d_after", v));
    end

    // Back-to-back single-channel events
    for (int c = 0; c < 13; c++) begin
      if (c < 10) begin
        qall = {8{4'(c + 2)}};
        drive_event(8'(1 << (c % 8)), qall, 4'd0, 8'(8'h20 + c));
      end else begin
        idle_inputs();
      end
      step();
      if (c >= 3) begin
        int e;
        e = c - 3;
        chk($sformatf("thr%0d.strobe", e), 32'(bus.out_strobe), 32'd1);
        chk($sformatf("thr%0d.valid", e), 32'(bus.out_valid), 32'd1);
        chk($sformatf("thr%0d.idx", e), 32'(bus.out_index[0]), 32'(e % 8));
        chk($sformatf("thr%0d.q", e), 32'(bus.out_quality[0]), 32'(e + 2));
        chk($sformatf("thr%0d.d", e), 32'(bus.out_data[0]), 32'(pay(e % 8, 8'(8'h20 + e))));
      end
    end
    step();
    check_quiet("thr_end");

    // overflow_clear wins over a simultaneous increment
    drive_event(vecs[3].valid, vecs[3].qual, 4'd0, 8'h50);
    step();
    drive_event(vecs[3].valid, vecs[3].qual, 4'd0, 8'h51);
    step();
    idle_inputs();
    step();
    step();
    chk("clr.first_cnt", 32'(bus.overflow_count), 32'(exp_cnt + 1));
    bus.overflow_clear = 1'b1;
    step();
    chk("clr.second_strobe", 32'(bus.out_strobe), 32'd1);
    chk("clr.second_ovf", 32'(bus.out_overflow), 32'd1);
    chk("clr.cnt", 32'(bus.overflow_count), 32'd0);
    bus.overflow_clear = 1'b0;
    step();
    chk("clr.cnt_hold", 32'(bus.overflow_count), 32'd0);
    exp_cnt = 0;

    // Saturation
    drive_event(8'hFF, {8{4'd0}}, 4'd0, 8'h60);
    for (int n = 0; n < 65540; n++) step();
    idle_inputs();
    for (int n = 0; n < 4; n++) step();
    chk("sat.cnt", 32'(bus.overflow_count), 32'hFFFF);

    // Reset while events are in flight and one is on the outputs
    drive_event(vecs[0].valid, vecs[0].qual, vecs[0].minq, 8'h70);
    step();
    drive_event(vecs[1].valid, vecs[1].qual, vecs[1].minq, 8'h71);
    step();
    idle_inputs();
    step();
    step();
    chk("rif.pre_strobe", 32'(bus.out_strobe), 32'd1);
    #3 reset = 1'b1;
    #1;
    check_quiet("rif.async");
    chk("rif.async_cnt", 32'(bus.overflow_count), 32'd0);
    exp_cnt = 0;
    step();
    step();
    #3 reset = 1'b0;
    for (int n = 0; n < 10; n++) begin
      step();
      chk($sformatf("rif.idle%0d", n), 32'(bus.out_strobe), 32'd0);
    end
    drive_event(vecs[0].valid, vecs[0].qual, vecs[0].minq, 8'h72);
    step();
    idle_inputs();
    step();
    step();
    chk("rif.early", 32'(bus.out_strobe), 32'd0);
    step();
    check_slots("rif.post", vecs[0], 8'h72);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipelined_quality_sorter.md
# pipelined_quality_sorter

Parametrised, fully pipelined sorter that selects the N_OUTPUTS highest-quality candidates out of N_INPUTS per event. Each candidate is a quality word plus payload, for example segment hits arriving from the SSGs. It accepts one event per clock and emits the winners in descending quality order, each with its source channel index, after a fixed latency. Compared with the previous sorter generation it adds:
- generic input and output counts;
- a runtime quality threshold;
- per-slot valid flags;
- an overflow flag and a saturating overflow counter.

## Interface
- N_INPUTS, 8: number of candidate channels; 1..64.
- N_OUTPUTS, 3: number of winners per event; 1 ≤ N_OUTPUTS ≤ N_INPUTS.
- QUAL_W, 4: quality width in bits; larger value means better.
- DATA_W, 16: payload width in bits.
- IDX_W, $clog2(N_INPUTS) (minimum 1): width of the channel index.
- LATENCY, N_OUTPUTS + 1: localparam, cycles from input strobe to output strobe.

Ports:
- clk  in  1  single clock; all logic is in this domain.
- reset  in  1  asynchronous, active-high; clears the whole pipeline.
- in_strobe  in  1  an event is present this cycle.
- in_valid  in  [N_INPUTS-1:0]  per-channel candidate present.
- in_quality  in  [QUAL_W-1:0] [N_INPUTS-1:0]  per-channel quality, unpacked array.
- in_data  in  [DATA_W-1:0] [N_INPUTS-1:0]  per-channel payload, unpacked array.
- min_quality  in  QUAL_W  threshold, sampled together with in_strobe.
- overflow_clear  in  1  synchronous clear of overflow_count.
- out_strobe  out  1  result for one event is present.
- out_valid  out  [N_OUTPUTS-1:0]  slot k holds a winner.
- out_quality  out  [QUAL_W-1:0] [N_OUTPUTS-1:0]  winner quality; slot 0 is best.
- out_data  out  [DATA_W-1:0] [N_OUTPUTS-1:0]  winner payload.
- out_index  out  [IDX_W-1:0] [N_OUTPUTS-1:0]  winner source channel.
- out_overflow  out  1  the event had more than N_OUTPUTS qualified candidates.
- overflow_count  out  16  saturating count of overflowed events.

## Operation
- Qualification: a channel is qualified when in_strobe = 1, in_valid[i] = 1 and in_quality[i] ≥ min_quality (unsigned compare). When in_strobe = 0, all of in_valid is ignored.
- Stage 0 registers the following: the qualified mask, all qualities and payloads, the strobe, and an overflow flag. The flag is set when popcount(mask) > N_OUTPUTS.
- Stage k (k = 1..N_OUTPUTS) operates on the remaining mask:
  - It selects the argmax of quality over that mask.
  - Tie rule: the lowest channel index wins.
  - It registers the winner's quality, payload and index, with valid = 1, into slot k-1.
  - It clears the winner's bit from the mask passed to stage k+1.
  - If the remaining mask is empty, slot k-1 gets valid = 0 with quality, data and index all 0.
- Earlier slots, the strobe and the overflow flag travel with the event through later stages, so all outputs are aligned in the same cycle.
- Output rules:
  - Slots are strictly non-increasing in quality.
  - Valid slots are contiguous from slot 0.
  - When out_strobe = 0, out_valid = 0, out_overflow = 0 and all slot fields are 0.
- overflow_count:
  - Increments by 1 in the cycle where out_strobe = 1 and out_overflow = 1.
  - Saturates at 0xFFFF.
  - overflow_clear forces it to 0 on the next edge and takes priority over a simultaneous increment.
- Payload is carried opaquely and never affects ordering.

## Timing
- Fully pipelined, with no backpressure. One event may be accepted every cycle, and back-to-back events never interact.
- An event with in_strobe at edge T produces out_strobe in the cycle after edge T + LATENCY - 1, i.e. LATENCY cycles later. For the default parameters LATENCY = 4.
- All outputs are registered, with no combinational path from any input to any output.
- Reset, asynchronous assert:
  - out_strobe, out_valid, out_overflow, all slot fields, overflow_count and every internal strobe/valid go to 0 immediately.
  - Events in flight are discarded. No out_strobe appears for events accepted before or during reset.
- Reset deassert: the first edge after deassert may accept a new event.
- min_quality changes take effect for the event strobed in the same cycle. Events already in the pipeline are unaffected.

## Test plan
- Reset: assert reset mid-run -> all outputs 0 asynchronously, overflow_count = 0. Release reset, then idle for 10 cycles -> out_strobe stays 0.
- Basic sort, defaults, min_quality = 0, all channels valid, qualities [3,9,1,9,7,0,2,5] for channels 0..7 -> 4 cycles later out_strobe = 1 with slots (q9, idx1), (q9, idx3), (q7, idx4), payloads matching, out_overflow = 1, overflow_count = 1.
- Threshold: same event with min_quality = 8 -> slot 0 = (q9, idx1), slot 1 = (q9, idx3), out_valid = 3'b011, slot 2 fields all 0, out_overflow = 0, overflow_count unchanged.
- Throughput: 10 consecutive strobed events, each with a single valid channel i = 0..9 mod 8 -> 10 consecutive out_strobe cycles in order, out_index matching and out_valid = 3'b001 each.
- Counter: 65 540 overflowing events -> overflow_count holds at 0xFFFF. overflow_clear coincident with an overflowed output -> count = 0 on the next cycle.
- Reset in flight: strobe an event at T, assert reset at T+2 -> no out_strobe at T+4. An event strobed after release comes out normally with latency 4.
